// File: rtl/ah_cam_pkg.sv
// Shared constants and types for the CAM access arbiter.
//   DW_DEF / KW_DEF / NREQ_DEF : default entry width, key width, requester count
//   idw(n)                     : requester-id width, clog2(n) with a floor of 1
//   rsp_stage_t                : one {valid, id} stage of the response pipeline
package ah_cam_pkg;
  localparam int DW_DEF   = 16;
  localparam int KW_DEF   = 8;
  localparam int NREQ_DEF = 4;
  localparam int IDW_MAX  = 3;  // wide enough for NREQ up to 8

  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDW = idw(NREQ_DEF);

  typedef struct packed {
    logic               valid;
    logic [IDW_MAX-1:0] id;
  } rsp_stage_t;
endpackage

// File: rtl/ah_rr_arb.sv
// Round-robin picker: first asserted req at or after ptr, wrapping mod NREQ.
//   req : request vector
//   ptr : highest-priority index this cycle (must be < NREQ)
//   gnt : one-hot grant (0 when no request)
//   win : index of the granted requester
//   any : at least one request present
module ah_rr_arb #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   win,
  output logic            any
);
  // Two passes: indices >= ptr first, then the wrapped-around low indices.
  always_comb begin
    gnt = '0;
    win = '0;
    any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (IW'(i) >= ptr)) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        win    = IW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i]) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        win    = IW'(i);
      end
    end
  end
endmodule

// File: rtl/ah_cam_access_arb.sv
// Shares one CAM between NREQ searchers and one writer, one op per cycle.
// Searches are round-robin and beat writes, except that a pending write wins
// after WR_STARVE consecutive search grants. Search results come back
// CAM_LAT cycles later, routed to the issuing requester via an id pipeline.
// Ports:
//   clk, rst_an                       clock, async active-low reset
//   req_svalid/req_skey/req_sready    search request, packed keys, grant
//   rsp_valid/rsp_match/rsp_data      one-hot response strobe, hit, hit data
//   wr_valid/wr_data/wr_ready         write request and accept
//   cam_wvalid/cam_wdata/cam_wcredit  CAM write port and free-slot credit
//   cam_svalid/cam_skey               CAM search issue
//   cam_smatch/cam_sdata              CAM result, CAM_LAT after issue
// Optional macro AH_CAM_ARB_STATS_EN adds stat_clr, stat_hits, stat_misses.
module ah_cam_access_arb
  import ah_cam_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int KW        = KW_DEF,
  parameter int CAM_LAT   = 1,
  parameter int WR_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst_an,
  input  logic [NREQ-1:0]   req_svalid,
  input  logic [NREQ*KW-1:0] req_skey,
  output logic [NREQ-1:0]   req_sready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_match,
  output logic [DW-1:0]     rsp_data,
  input  logic              wr_valid,
  input  logic [DW-1:0]     wr_data,
  output logic              wr_ready,
`ifdef AH_CAM_ARB_STATS_EN
  input  logic              stat_clr,
  output logic [15:0]       stat_hits,
  output logic [15:0]       stat_misses,
`endif
  output logic              cam_wvalid,
  output logic [DW-1:0]     cam_wdata,
  input  logic              cam_wcredit,
  output logic              cam_svalid,
  output logic [KW-1:0]     cam_skey,
  input  logic              cam_smatch,
  input  logic [DW-1:0]     cam_sdata
);
  localparam int IW = idw(NREQ);
  localparam int SW = $clog2(WR_STARVE + 1);

  logic [IW-1:0]   rr_ptr;
  logic [SW-1:0]   starve_cnt;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   win;
  logic            any_req;
  logic [KW-1:0]   skey_sel;
  logic            s_pend, wr_elig, wr_gnt, s_gnt;
  rsp_stage_t [CAM_LAT-1:0] pipe;
  rsp_stage_t      fin;

  ah_rr_arb #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req (req_svalid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .win (win),
    .any (any_req)
  );

  // Grants are masked while in reset so nothing issues to the CAM.
  assign s_pend  = rst_an & any_req;
  assign wr_elig = rst_an & wr_valid & cam_wcredit;
  assign wr_gnt  = wr_elig & (~s_pend | (starve_cnt == SW'(WR_STARVE)));
  assign s_gnt   = s_pend & ~wr_gnt;

  always_comb begin
    skey_sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) skey_sel = skey_sel | req_skey[i*KW +: KW];
  end

  assign req_sready = s_gnt ? gnt : '0;
  assign cam_svalid = s_gnt;
  assign cam_skey   = s_gnt ? skey_sel : '0;
  assign wr_ready   = wr_gnt;
  assign cam_wvalid = wr_gnt;
  assign cam_wdata  = wr_gnt ? wr_data : '0;

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      if (s_gnt) rr_ptr <= (win == IW'(NREQ-1)) ? '0 : win + IW'(1);
      // Count only consecutive search wins that actually held a write off.
      if (!wr_elig || wr_gnt)
        starve_cnt <= '0;
      else if (s_gnt && starve_cnt != SW'(WR_STARVE))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // {valid,id} shift register aligned with the CAM's fixed latency.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      pipe <= '0;
    end else begin
      pipe[0].valid <= s_gnt;
      pipe[0].id    <= IDW_MAX'(win);
      for (int s = 1; s < CAM_LAT; s++) pipe[s] <= pipe[s-1];
    end
  end

  assign fin       = pipe[CAM_LAT-1];
  assign rsp_valid = fin.valid ? (NREQ'(1) << fin.id[IW-1:0]) : '0;
  assign rsp_match = fin.valid & cam_smatch;
  assign rsp_data  = (fin.valid & cam_smatch) ? cam_sdata : '0;

`ifdef AH_CAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (stat_clr) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (fin.valid) begin
      if (cam_smatch) begin
        if (stat_hits != '1) stat_hits <= stat_hits + 16'd1;
      end else begin
        if (stat_misses != '1) stat_misses <= stat_misses + 16'd1;
      end
    end
  end
`endif
endmodule

// File: doc/ah_cam_access_arb.md
Name: ah_cam_access_arb

Overview:
Shares one CAM between NREQ search requesters and one write requester; at most one CAM operation is issued per cycle.
Round-robin arbitration among searchers; searches have priority over writes, bounded by an anti-starvation counter.
Tags each issued search with its requester id and routes the CAM result back after a fixed CAM_LAT pipeline.
Sits between the lookup clients and the CAM allocation/storage block.

Parameters:
NREQ, 4, number of search requesters (2..8)
DW, 16, CAM entry data width
KW, 8, search key width (low KW bits of the entry)
CAM_LAT, 1, cycles from cam_svalid issue to cam_smatch/cam_sdata valid (1..4)
WR_STARVE, 4, max consecutive search grants while a write is pending

Ports:
clk  in  1  clock
rst_an  in  1  asynchronous active-low reset
req_svalid  in  NREQ  per-requester search request
req_skey  in  NREQ*KW  packed keys, requester i at [i*KW +: KW]
req_sready  out  NREQ  one-hot grant / accept
rsp_valid  out  NREQ  one-hot response strobe
rsp_match  out  1  hit flag for the current response
rsp_data  out  DW  hit data; 0 on a miss
wr_valid  in  1  write request
wr_data  in  DW  write entry
wr_ready  out  1  write accepted
cam_wvalid  out  1  CAM write strobe
cam_wdata  out  DW  CAM write data
cam_wcredit  in  1  CAM has a free location
cam_svalid  out  1  CAM search strobe
cam_skey  out  KW  CAM search key
cam_smatch  in  1  CAM hit, CAM_LAT cycles after cam_svalid
cam_sdata  in  DW  CAM hit data, aligned with cam_smatch

Behaviour:
- Reset is rst_an, asynchronous, active-low; clock is clk. Reset clears rr_ptr=0, starve_cnt=0, and the id/valid pipeline; rsp_valid=0, rsp_match=0, rsp_data=0. Combinational outputs are 0 when no request is asserted.
- Write eligibility: wr_elig = wr_valid & cam_wcredit.
- Any search pending (S = |req_svalid):
  - Grant the write if wr_elig & (~S | starve_cnt==WR_STARVE).
  - Otherwise, if S, grant the search winner.
- Write grant: cam_wvalid=1, cam_wdata=wr_data, wr_ready=1, starve_cnt<=0, same cycle. Write only; no response is generated.
- Search winner: first i with req_svalid[i], scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_sready[i]=1, cam_svalid=1, cam_skey=key[i], all in the same cycle.
  - Next rr_ptr = (i+1) mod NREQ.
- starve_cnt:
  - increments (saturating at WR_STARVE) on a search grant while wr_elig;
  - clears when wr_elig=0 or on a write grant.
- wr_ready=0 whenever cam_wcredit=0, regardless of priority.
- Response pipeline: CAM_LAT stages of {valid, id}.
  - Stage 0 loads {1, i} on a search grant, else {0, x}.
  - On the final stage valid: rsp_valid = onehot(id), rsp_match = cam_smatch, rsp_data = cam_smatch ? cam_sdata : 0.
  - Total search latency is CAM_LAT cycles. No response backpressure: requesters always accept.
- Responses are strictly in issue order; back-to-back searches give one response per cycle.
- A request dropped before grant is legal. Once asserted, req_skey must be held stable until req_sready.
- Write followed by a search of the same key next cycle: the search sees the new entry (CAM updates on the write edge).
- Reset mid-operation discards in-flight responses; none are emitted after reset release.
- NREQ=1 degenerates to a fixed grant with rr_ptr constant 0.

Optional Feature:
AH_CAM_ARB_STATS_EN:
- Defined: adds outputs stat_hits[15:0] and stat_misses[15:0]. Saturating counters increment on each response with rsp_match=1 / 0. Reset to 0; synchronous clear input stat_clr.
- Undefined: ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package ah_cam_pkg: DW/KW defaults, the id-width constant (IDW = clog2 of NREQ, min 1), and the response-stage struct {valid, id}.
- One sub-module, ah_rr_arb: parameterised NREQ round-robin picker (req vector, ptr in; one-hot grant, winner index out).
- Starve counter, write/search mux and response pipeline stay in the top.

Test Plan:
- Reset: hold rst_an=0 with all requests high -> all outputs 0; release -> first grant goes to req0 (rr_ptr=0).
- Round-robin: req_svalid=4'b1111 for 4 cycles, no write -> grants 0,1,2,3; responses at +CAM_LAT with matching one-hot rsp_valid.
- Starvation bound (WR_STARVE=4): searches saturated, wr_valid=1, cam_wcredit=1 -> 4 search grants, then the write granted on the 5th cycle; repeats every 5 cycles.
- Credit block: wr_valid=1, cam_wcredit=0, no searches -> wr_ready stays 0 and cam_wvalid=0; raise credit -> write granted same cycle.
- Hit/miss: write 16'hA55A, then search key 8'h5A from req2 -> rsp_valid=4'b0100, rsp_match=1, rsp_data=16'hA55A. Search key 8'h33 -> rsp_match=0, rsp_data=0.
- Reset during flight: assert rst_an with CAM_LAT=3 and 2 searches in flight -> no rsp_valid after release; with AH_CAM_ARB_STATS_EN, 3 hits + 1 miss -> stat_hits=3, stat_misses=1.
